// File: rtl/branch_pkg.sv
// branch_pkg: shared BTB entry type, counter encoding and PC index/tag helpers
package branch_pkg;
   typedef logic [1:0] ctr_t;
   localparam ctr_t CTR_SNT = 2'b00;
   localparam ctr_t CTR_WNT = 2'b01;
   localparam ctr_t CTR_WT  = 2'b10;
   localparam ctr_t CTR_ST  = 2'b11;
   typedef struct packed {
      logic        valid;
      logic [31:0] tag;
      logic [31:0] target;
      ctr_t        ctr;
   } btb_entry_t;
   localparam btb_entry_t BTB_RESET = '{valid: 1'b0, tag: 32'd0, target: 32'd0, ctr: CTR_WNT};
   function automatic logic [31:0] pc_idx(input logic [31:0] pc, input int idx_w);
      return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
   endfunction
   function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w);
      return pc >> (idx_w + 2);
   endfunction
endpackage

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB storage, IF read port plus EX read-modify-write port
module branch_target_buffer
   import branch_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd_idx,
   output btb_entry_t       rd_entry,
   input  logic [IDX_W-1:0] wr_idx,
   output btb_entry_t       wr_cur,
   input  logic             wr_en,
   input  btb_entry_t       wr_entry
);
   btb_entry_t mem [DEPTH];
   assign rd_entry = mem[rd_idx];
   assign wr_cur   = mem[wr_idx];
   // reads see the old contents; the write lands at the clock edge
   always_ff @(posedge clk)
      if (reset)
         for (int i = 0; i < DEPTH; i++) mem[i] <= BTB_RESET;
      else if (wr_en)
         mem[wr_idx] <= wr_entry;
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: BTB-based fetch prediction, EX resolution with redirect, statistics
module branch_predict_unit
   import branch_pkg::*;
#(
   parameter int PC_W      = 9,
   parameter int BTB_DEPTH = 16,
   parameter int STAT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PC_W-1:0]   if_pc,
   output logic              if_pred_taken,
   output logic [31:0]       if_pred_target,
   input  logic              ex_valid,
   input  logic              ex_stall,
   input  logic [PC_W-1:0]   ex_pc,
   input  logic [31:0]       ex_imm,
   input  logic              ex_branch,
   input  logic              ex_jump,
   input  logic              ex_jalr,
   input  logic [31:0]       ex_alu_result,
   input  logic              ex_pred_taken,
   input  logic [31:0]       ex_pred_target,
   output logic [31:0]       pc_four,
   output logic [31:0]       redirect_pc,
   output logic              pc_sel,
   output logic              flush,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispredict
);
   localparam int IDX_W = $clog2(BTB_DEPTH);
   logic [31:0] if_pc32, ex_pc32, ex_tag, target;
   logic [IDX_W-1:0] if_idx, ex_idx;
   btb_entry_t if_ent, ex_ent, wr_ent;
   logic wr_en, if_hit, ex_hit, act, ctl, res, taken, mispredict;
   assign if_pc32 = 32'(if_pc);
   assign ex_pc32 = 32'(ex_pc);
   assign if_idx  = IDX_W'(pc_idx(if_pc32, IDX_W));
   assign ex_idx  = IDX_W'(pc_idx(ex_pc32, IDX_W));
   assign ex_tag  = pc_tag(ex_pc32, IDX_W);
   branch_target_buffer #(.DEPTH(BTB_DEPTH), .IDX_W(IDX_W)) u_btb (
      .clk(clk), .reset(reset), .rd_idx(if_idx), .rd_entry(if_ent),
      .wr_idx(ex_idx), .wr_cur(ex_ent), .wr_en(wr_en), .wr_entry(wr_ent)
   );
   assign if_hit         = if_ent.valid && if_ent.tag == pc_tag(if_pc32, IDX_W);
   assign if_pred_taken  = if_hit && if_ent.ctr[1];
   assign if_pred_target = if_pred_taken ? if_ent.target : 32'd0;
   assign ex_hit      = ex_ent.valid && ex_ent.tag == ex_tag;
   assign act         = ex_valid && !ex_stall;
   assign ctl         = ex_branch || ex_jump || ex_jalr;
   assign res         = act && ctl;
   assign taken       = ex_jalr || ex_jump || ex_alu_result[0];
   assign target      = ex_jalr ? (ex_alu_result & ~32'h1) : ex_pc32 + ex_imm;
   assign pc_four     = ex_pc32 + 32'd4;
   assign mispredict  = res ? (taken != ex_pred_taken || (taken && target != ex_pred_target))
                            : act && ex_pred_taken;
   assign redirect_pc = res ? (taken ? target : pc_four) : (mispredict ? pc_four : 32'd0);
   assign pc_sel      = mispredict;
   assign flush       = mispredict;
   // train the entry at ex_pc: strengthen/allocate on taken, weaken on not-taken, drop aliased hits
   always_comb begin
      wr_ent = ex_ent;
      wr_en  = 1'b0;
      if (res && taken) begin
         wr_en         = 1'b1;
         wr_ent.valid  = 1'b1;
         wr_ent.tag    = ex_tag;
         wr_ent.target = target;
         wr_ent.ctr    = !ex_hit ? ((ex_jump || ex_jalr) ? CTR_ST : CTR_WT)
                                 : (ex_ent.ctr == CTR_ST ? CTR_ST : ex_ent.ctr + 2'd1);
      end else if (res && ex_hit) begin
         wr_en      = 1'b1;
         wr_ent.ctr = ex_ent.ctr == CTR_SNT ? CTR_SNT : ex_ent.ctr - 2'd1;
      end else if (act && !ctl && ex_pred_taken && ex_hit) begin
         wr_en        = 1'b1;
         wr_ent.valid = 1'b0;
      end
   end
   // saturating resolve and mispredict counters
   always_ff @(posedge clk)
      if (reset) begin
         stat_branches   <= '0;
         stat_mispredict <= '0;
      end else begin
         if (res && stat_branches != '1) stat_branches <= stat_branches + STAT_W'(1);
         if (mispredict && stat_mispredict != '1) stat_mispredict <= stat_mispredict + STAT_W'(1);
      end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed and randomized checks against a behavioural BTB model
module tb_branch_predict_unit;
   localparam int PC_W = 9, D = 16, SW = 4, SMAX = (1 << SW) - 1;
   logic clk = 0, reset = 1;
   logic [PC_W-1:0] if_pc = '0, ex_pc = '0;
   logic ex_valid = 0, ex_stall = 0, ex_branch = 0, ex_jump = 0, ex_jalr = 0, ex_pred_taken = 0;
   logic [31:0] ex_imm = '0, ex_alu_result = '0, ex_pred_target = '0;
   logic if_pred_taken, pc_sel, flush;
   logic [31:0] if_pred_target, pc_four, redirect_pc;
   logic [SW-1:0] stat_branches, stat_mispredict;
   int checks = 0, bad = 0;
   int m_v[D], m_tag[D], m_ctr[D], m_sb, m_sm;
   logic [31:0] m_tgt[D];
   logic e_pt, e_sel;
   logic [31:0] e_ptgt, e_rd, e_p4;

   branch_predict_unit #(.PC_W(PC_W), .BTB_DEPTH(D), .STAT_W(SW)) dut (
      .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
      .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc),
      .ex_imm(ex_imm), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
      .ex_alu_result(ex_alu_result), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .pc_four(pc_four), .redirect_pc(redirect_pc), .pc_sel(pc_sel), .flush(flush),
      .stat_branches(stat_branches), .stat_mispredict(stat_mispredict)
   );

   always #5 clk = ~clk;

   function automatic int ix(int pc); return (pc / 4) % D; endfunction
   function automatic int tg(int pc); return pc / (4 * D); endfunction
   function automatic bit m_hit(int pc); return m_v[ix(pc)] != 0 && m_tag[ix(pc)] == tg(pc); endfunction

   task automatic model_eval(output bit res, output bit tk, output logic [31:0] t);
      bit act, ctl;
      int pc = int'(if_pc);
      act = ex_valid && !ex_stall;
      ctl = ex_branch || ex_jump || ex_jalr;
      res = act && ctl;
      if (ex_jalr) begin tk = 1; t = ex_alu_result & ~32'h1; end
      else if (ex_jump) begin tk = 1; t = 32'(ex_pc) + ex_imm; end
      else begin tk = ex_alu_result[0]; t = 32'(ex_pc) + ex_imm; end
      e_pt   = m_hit(pc) && m_ctr[ix(pc)] >= 2;
      e_ptgt = e_pt ? m_tgt[ix(pc)] : 32'd0;
      e_p4   = 32'(ex_pc) + 32'd4;
      e_sel  = res ? (tk != ex_pred_taken || (tk && t != ex_pred_target)) : (act && ex_pred_taken);
      e_rd   = res ? (tk ? t : e_p4) : (e_sel ? e_p4 : 32'd0);
   endtask

   task automatic model_commit;
      bit res, tk, h;
      logic [31:0] t;
      int i = ix(int'(ex_pc));
      if (reset) begin
         for (int k = 0; k < D; k++) begin m_v[k] = 0; m_ctr[k] = 1; m_tgt[k] = 0; m_tag[k] = 0; end
         m_sb = 0; m_sm = 0;
         return;
      end
      model_eval(res, tk, t);
      h = m_hit(int'(ex_pc));
      if (res && tk) begin
         m_ctr[i] = h ? (m_ctr[i] < 3 ? m_ctr[i] + 1 : 3) : ((ex_jump || ex_jalr) ? 3 : 2);
         m_v[i] = 1; m_tag[i] = tg(int'(ex_pc)); m_tgt[i] = t;
      end else if (res && h) m_ctr[i] = m_ctr[i] > 0 ? m_ctr[i] - 1 : 0;
      else if (ex_valid && !ex_stall && !(ex_branch || ex_jump || ex_jalr) && ex_pred_taken && h) m_v[i] = 0;
      if (res && m_sb < SMAX) m_sb++;
      if (e_sel && m_sm < SMAX) m_sm++;
   endtask

   task automatic tick;
      model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic st, input int pc, input logic [31:0] imm,
                         input logic br, input logic j, input logic jr, input logic [31:0] alu,
                         input logic pt, input logic [31:0] ptgt);
      ex_valid = v; ex_stall = st; ex_pc = PC_W'(pc); ex_imm = imm; ex_branch = br;
      ex_jump = j; ex_jalr = jr; ex_alu_result = alu; ex_pred_taken = pt; ex_pred_target = ptgt;
      #1;
   endtask

   task automatic clear_ex;
      set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic look(input int pc);
      if_pc = PC_W'(pc);
      #1;
   endtask

   task automatic test_reset;
      reset = 1; tick(); tick(); reset = 0;
      look('h010);
      if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred got=%0h want=0", if_pred_taken); end checks++;
      if (if_pred_target !== 32'd0) begin bad++; $display("FAIL reset_target got=%0h want=0", if_pred_target); end checks++;
      if (stat_branches !== '0 || stat_mispredict !== '0) begin bad++; $display("FAIL reset_stats got=%0h/%0h want=0/0", stat_branches, stat_mispredict); end checks++;
      if (pc_sel !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'd0) begin bad++; $display("FAIL reset_redirect got=%0h/%0h/%0h want=0/0/0", pc_sel, flush, redirect_pc); end checks++;
      if (pc_four !== 32'd4) begin bad++; $display("FAIL reset_pc_four got=%0h want=4", pc_four); end checks++;
   endtask

   task automatic test_branch_counter;
      set_ex(1, 0, 'h20, 'h40, 1, 0, 0, 1, 0, 0);
      if (pc_sel !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h60) begin bad++; $display("FAIL br_taken_redirect got=%0h/%0h/%0h want=1/1/60", pc_sel, flush, redirect_pc); end checks++;
      tick(); clear_ex(); look('h20);
      if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h60) begin bad++; $display("FAIL br_alloc_lookup got=%0h/%0h want=1/60", if_pred_taken, if_pred_target); end checks++;
      if (stat_branches !== 4'd1 || stat_mispredict !== 4'd1) begin bad++; $display("FAIL br_stats got=%0h/%0h want=1/1", stat_branches, stat_mispredict); end checks++;
      set_ex(1, 0, 'h20, 'h40, 1, 0, 0, 0, 1, 'h60);
      if (pc_sel !== 1'b1 || redirect_pc !== 32'h24) begin bad++; $display("FAIL br_nt1_redirect got=%0h/%0h want=1/24", pc_sel, redirect_pc); end checks++;
      tick(); clear_ex(); look('h20);
      if (if_pred_taken !== 1'b0 || if_pred_target !== 32'd0) begin bad++; $display("FAIL br_nt1_lookup got=%0h/%0h want=0/0", if_pred_taken, if_pred_target); end checks++;
      set_ex(1, 0, 'h20, 'h40, 1, 0, 0, 0, 0, 0);
      if (pc_sel !== 1'b0 || redirect_pc !== 32'h24) begin bad++; $display("FAIL br_nt2_redirect got=%0h/%0h want=0/24", pc_sel, redirect_pc); end checks++;
      tick(); tick();
      set_ex(1, 0, 'h20, 'h40, 1, 0, 0, 1, 0, 0);
      tick(); clear_ex(); look('h20);
      if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL br_ctr_floor got=%0h want=0", if_pred_taken); end checks++;
      if (stat_branches !== 4'd5 || stat_mispredict !== 4'd3) begin bad++; $display("FAIL br_stats2 got=%0h/%0h want=5/3", stat_branches, stat_mispredict); end checks++;
   endtask

   task automatic test_jalr;
      set_ex(1, 0, 'h40, 0, 0, 0, 1, 'h101, 1, 'h100);
      if (pc_sel !== 1'b0 || redirect_pc !== 32'h100) begin bad++; $display("FAIL jalr_redirect got=%0h/%0h want=0/100", pc_sel, redirect_pc); end checks++;
      tick(); clear_ex(); look('h40);
      if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h100) begin bad++; $display("FAIL jalr_lookup got=%0h/%0h want=1/100", if_pred_taken, if_pred_target); end checks++;
   endtask

   task automatic test_alias;
      set_ex(1, 0, 'h30, 'h10, 1, 0, 0, 1, 0, 0); tick();
      set_ex(1, 0, 'h70, 'h20, 0, 1, 0, 0, 0, 0);
      if (pc_sel !== 1'b1 || redirect_pc !== 32'h90) begin bad++; $display("FAIL alias_jump_redirect got=%0h/%0h want=1/90", pc_sel, redirect_pc); end checks++;
      tick(); clear_ex(); look('h30);
      if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL alias_evicted got=%0h want=0", if_pred_taken); end checks++;
      look('h70);
      if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h90) begin bad++; $display("FAIL alias_new got=%0h/%0h want=1/90", if_pred_taken, if_pred_target); end checks++;
      set_ex(1, 0, 'h70, 0, 0, 0, 0, 0, 1, 'h90);
      if (pc_sel !== 1'b1 || redirect_pc !== 32'h74) begin bad++; $display("FAIL alias_nonctl got=%0h/%0h want=1/74", pc_sel, redirect_pc); end checks++;
      tick(); clear_ex(); look('h70);
      if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL alias_invalidate got=%0h want=0", if_pred_taken); end checks++;
   endtask

   task automatic test_stall;
      set_ex(1, 1, 'h80, 'h8, 1, 0, 0, 1, 0, 0);
      if (pc_sel !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'd0) begin bad++; $display("FAIL stall_redirect got=%0h/%0h/%0h want=0/0/0", pc_sel, flush, redirect_pc); end checks++;
      tick(); clear_ex(); look('h80);
      if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL stall_no_update got=%0h want=0", if_pred_taken); end checks++;
      if (int'(stat_branches) != m_sb || int'(stat_mispredict) != m_sm) begin bad++; $display("FAIL stall_stats got=%0d/%0d want=%0d/%0d", stat_branches, stat_mispredict, m_sb, m_sm); end checks++;
   endtask

   task automatic test_reset_mid;
      set_ex(1, 0, 'h90, 'h8, 1, 0, 0, 1, 0, 0);
      reset = 1; tick(); reset = 0; clear_ex(); look('h90);
      if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL rst_mid_drop got=%0h want=0", if_pred_taken); end checks++;
      look('h40);
      if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL rst_mid_clear got=%0h want=0", if_pred_taken); end checks++;
      if (stat_branches !== '0 || stat_mispredict !== '0) begin bad++; $display("FAIL rst_mid_stats got=%0h/%0h want=0/0", stat_branches, stat_mispredict); end checks++;
   endtask

   task automatic test_random;
      bit res, tk;
      logic [31:0] t;
      int pc;
      for (int n = 0; n < 400; n++) begin
         if (int'(stat_branches) != m_sb || int'(stat_mispredict) != m_sm) begin bad++; $display("FAIL rnd_stats n=%0d got=%0d/%0d want=%0d/%0d", n, stat_branches, stat_mispredict, m_sb, m_sm); end checks++;
         pc = $urandom_range(0, 47) * 4;
         set_ex($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, pc, 32'($urandom_range(0, 255)) - 32'd128,
                $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom, 0, 0);
         if ($urandom_range(0, 1)) begin
            ex_pred_taken  = m_hit(pc) && m_ctr[ix(pc)] >= 2;
            ex_pred_target = ex_pred_taken ? m_tgt[ix(pc)] : 32'd0;
         end else begin
            ex_pred_taken  = $urandom_range(0, 1);
            ex_pred_target = $urandom_range(0, 1) ? 32'(ex_pc) + ex_imm : 32'($urandom_range(0, 511));
         end
         look($urandom_range(0, 1) ? pc : $urandom_range(0, 47) * 4);
         model_eval(res, tk, t);
         if (if_pred_taken !== e_pt || if_pred_target !== e_ptgt) begin bad++; $display("FAIL rnd_lookup n=%0d got=%0h/%0h want=%0h/%0h", n, if_pred_taken, if_pred_target, e_pt, e_ptgt); end checks++;
         if (pc_sel !== e_sel || flush !== e_sel) begin bad++; $display("FAIL rnd_sel n=%0d got=%0h/%0h want=%0h", n, pc_sel, flush, e_sel); end checks++;
         if (redirect_pc !== e_rd) begin bad++; $display("FAIL rnd_redirect n=%0d got=%0h want=%0h", n, redirect_pc, e_rd); end checks++;
         if (pc_four !== e_p4) begin bad++; $display("FAIL rnd_pc_four n=%0d got=%0h want=%0h", n, pc_four, e_p4); end checks++;
         tick();
      end
      clear_ex();
   endtask

   task automatic test_saturation;
      reset = 1; tick(); reset = 0;
      for (int n = 0; n < SMAX + 5; n++) begin
         set_ex(1, 0, n * 4, 'h100, 0, 1, 0, 0, 0, 0);
         tick();
      end
      clear_ex();
      if (stat_branches !== 4'hF || stat_mispredict !== 4'hF) begin bad++; $display("FAIL stat_saturate got=%0h/%0h want=f/f", stat_branches, stat_mispredict); end checks++;
   endtask

   initial begin
      #1;
      test_reset();
      test_branch_counter();
      test_jalr();
      test_alias();
      test_stall();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("test done: total=%0d bad=%0d", checks, bad);
      $finish;
   end
endmodule
